multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencer for the RV-style datapath that shares one memory port between instruction fetch and data access. It walks each instruction through fetch, decode, execute, memory and write-back states. It drives every mux select and write enable of the datapath, waits on a memory ready handshake, and raises `Done` on the halt opcode. It also counts retired instructions.

## Interface
- `HALT_OP`, 7'h7F, opcode that stops the sequencer.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Op` in 7: opcode from the instruction register. Encodings: R=0, LW=1, ADDI=2, XORI=3, ORI=4, SLTI=5, JALR=6, SW=7, JAL=8, BEQ=9, BNE=10, BLT=11, BGE=12, LUI=13.
- `F3` in 3: ALU function field.
- `Zero` in 1: ALU result is zero.
- `SignBit` in 1: ALU result bit 31.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `MemWrite` out 1: the request is a write.
- `AdrSel` out 1: memory address source; 0=PC, 1=ALUOut.
- `IrWrite` out 1: load the instruction register and the OldPC register.
- `PcWrite` out 1: load the PC.
- `PcSrc` out 1: PC source; 0=ALU result, 1=ALUOut.
- `RegWrite` out 1: register-file write enable.
- `AluSrcA` out 2: ALU A input; 00=PC, 01=OldPC, 10=Rs1 register, 11=zero.
- `AluSrcB` out 2: ALU B input; 00=Rs2 register, 01=Imm, 10=constant 4.
- `AluIn` out 3: ALU function; ADD=000, SUB=001, otherwise F3.
- `ResultSel` out 2: write-back source; 00=ALUOut, 01=MemData, 10=ALU result, 11=PC.
- `ImmSel` out 3: immediate format, decoded from Op in every state.
  - 000 for LW, ADDI, XORI, ORI, SLTI, JALR.
  - 001 for SW.
  - 010 for B-type.
  - 011 for JAL.
  - 100 for LUI.
  - 000 for any other Op.
- `Done` out 1: halted.
- `InstrCount` out 32: number of retired instructions.

## Operation
- States: FETCH, DECODE, EX_R, EX_I, MEM_ADR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, DONE.
- Any output not listed for a state is 0, except `ImmSel`.
- FETCH
  - Drives `mem_req`=1, `AdrSel`=0, `AluSrcA`=00, `AluSrcB`=10, `AluIn`=ADD, `PcSrc`=0.
  - On `mem_ready`: `IrWrite`=1 and `PcWrite`=1, then go to DECODE. Without `mem_ready`, stay in FETCH.
- DECODE
  - Drives `AluSrcA`=01, `AluSrcB`=01, ADD, so the branch/JAL target is latched into ALUOut.
  - Next state by Op:
    - R → EX_R.
    - ADDI, XORI, ORI, SLTI → EX_I.
    - LW, SW → MEM_ADR.
    - JALR → JALR.
    - JAL → JAL.
    - BEQ, BNE, BLT, BGE → BRANCH.
    - LUI → LUI.
    - `HALT_OP` → DONE.
    - Any other Op → FETCH, treated as a NOP.
- EX_R: `AluSrcA`=10, `AluSrcB`=00, `AluIn`=F3, then WB_ALU.
- EX_I: `AluSrcA`=10, `AluSrcB`=01, `AluIn`=F3, then WB_ALU.
- WB_ALU: `RegWrite`=1, `ResultSel`=00, then FETCH.
- MEM_ADR: `AluSrcA`=10, `AluSrcB`=01, ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_req`=1, `AdrSel`=1. On `mem_ready` go to WB_MEM; otherwise stay.
- WB_MEM: `RegWrite`=1, `ResultSel`=01, then FETCH.
- MEM_WR: `mem_req`=1, `MemWrite`=1, `AdrSel`=1. On `mem_ready` go to FETCH; otherwise stay.
- BRANCH
  - Drives `AluSrcA`=10, `AluSrcB`=00, SUB, `PcSrc`=1.
  - `PcWrite` is 1 only when the branch is taken:
    - BEQ: `Zero`.
    - BNE: `~Zero`.
    - BLT: `SignBit`.
    - BGE: `~SignBit`.
  - Always goes to FETCH.
- JAL: `RegWrite`=1, `ResultSel`=11, `PcWrite`=1, `PcSrc`=1, then FETCH.
- JALR: `AluSrcA`=10, `AluSrcB`=01, ADD, `PcWrite`=1, `PcSrc`=0, `RegWrite`=1, `ResultSel`=11, then FETCH.
  - rd receives the pre-update PC, which is the return address.
- LUI: `AluSrcA`=11, `AluSrcB`=01, ADD, `RegWrite`=1, `ResultSel`=10, then FETCH.
- DONE: `Done`=1 and no other output is active. The controller stays in DONE until `rst`.
- `InstrCount`
  - Increments by 1 on every transition into FETCH from any state other than FETCH, including the NOP path.
  - Wraps from 2^32−1 to 0.
  - Does not increment when entering DONE.

## Timing
- Reset
  - While `rst` is sampled high at a clock edge, the next state is FETCH and `InstrCount` becomes 0.
  - During any cycle in which `rst` is high, every output except `ImmSel` is forced to 0. This covers `mem_req`, `PcWrite`, `RegWrite` and `Done`.
  - Reset mid-instruction, including while waiting on `mem_ready`, abandons the instruction without any write.
- Enable and select outputs are Moore-decoded from the state. The exceptions are `IrWrite` and `PcWrite` in FETCH, which are gated by `mem_ready`, and `PcWrite` in BRANCH, which is gated by the condition.
- Memory handshake
  - `mem_req`, `AdrSel` and `MemWrite` stay stable until the cycle in which `mem_ready`=1.
  - `mem_ready` is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- Cycles per instruction with zero-wait memory (`mem_ready` always 1):
  - R, I-ALU, SW: 4.
  - LW: 5.
  - Branch, JAL, JALR, LUI: 3.
  - Each memory wait cycle adds 1.

## Test plan
- Reset with `mem_ready`=0:
  - During reset all outputs are 0.
  - After reset: `mem_req`=1, `AdrSel`=0, `IrWrite`=0, and the FETCH state is held for 3 cycles.
  - When `mem_ready` rises: `IrWrite`=`PcWrite`=1 for exactly one cycle.
- R-type, Op=0, F3=3'b100, zero-wait memory:
  - Sequence FETCH, DECODE, EX_R (`AluIn`=100), WB_ALU (`RegWrite`=1, `ResultSel`=00).
  - `InstrCount` becomes 1 in cycle 5.
- LW with 2 wait cycles:
  - `mem_req`=1 with `AdrSel`=1 for 3 cycles in MEM_RD.
  - Then WB_MEM with `ResultSel`=01.
  - Total 7 cycles.
- Branch conditions, one case per type:
  - BEQ with `Zero`=1 → `PcWrite`=1, `PcSrc`=1.
  - BNE with `Zero`=1 → `PcWrite`=0.
  - BLT with `SignBit`=1 → `PcWrite`=1.
  - BGE with `SignBit`=1 → `PcWrite`=0.
  - Each takes 3 cycles.
- JAL then JALR:
  - JAL state: `RegWrite`=1, `ResultSel`=11, `PcWrite`=1, `PcSrc`=1.
  - JALR state: same, but `PcSrc`=0, `AluSrcA`=10, `AluSrcB`=01.
- Halt and mid-operation reset:
  - Op=7'h7F → `Done`=1 held for 10 cycles, `InstrCount` frozen.
  - Reset asserted in MEM_WR → no `MemWrite` after reset; FETCH resumes with `InstrCount`=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle shared by instruction fetch and data access.
//   mem_req   : controller requests a memory transfer
//   MemWrite  : the request is a write
//   AdrSel    : address source, 0=PC, 1=ALUOut
//   mem_ready : memory completes the current request this cycle
interface multicycle_controller_if;
  logic mem_req;
  logic MemWrite;
  logic AdrSel;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, output AdrSel, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer for a shared-memory RV-style datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back,
// drives every datapath select and write enable, raises Done on HALT_OP and
// counts retired instructions.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mem           : memory handshake (master side)
//   Op, F3        : opcode and ALU function from the instruction register
//   Zero, SignBit : ALU result flags used for branch resolution
//   IrWrite, PcWrite, PcSrc, RegWrite, AluSrcA, AluSrcB, AluIn,
//   ResultSel, ImmSel : datapath controls
//   Done          : halted
//   InstrCount    : retired-instruction counter
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        mem,
  input  logic [6:0]                     Op,
  input  logic [2:0]                     F3,
  input  logic                           Zero,
  input  logic                           SignBit,
  output logic                           IrWrite,
  output logic                           PcWrite,
  output logic                           PcSrc,
  output logic                           RegWrite,
  output logic [1:0]                     AluSrcA,
  output logic [1:0]                     AluSrcB,
  output logic [2:0]                     AluIn,
  output logic [1:0]                     ResultSel,
  output logic [2:0]                     ImmSel,
  output logic                           Done,
  output logic [31:0]                    InstrCount
);

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OP_R    = 7'd0;
  localparam logic [6:0] OP_LW   = 7'd1;
  localparam logic [6:0] OP_ADDI = 7'd2;
  localparam logic [6:0] OP_XORI = 7'd3;
  localparam logic [6:0] OP_ORI  = 7'd4;
  localparam logic [6:0] OP_SLTI = 7'd5;
  localparam logic [6:0] OP_JALR = 7'd6;
  localparam logic [6:0] OP_SW   = 7'd7;
  localparam logic [6:0] OP_JAL  = 7'd8;
  localparam logic [6:0] OP_BEQ  = 7'd9;
  localparam logic [6:0] OP_BNE  = 7'd10;
  localparam logic [6:0] OP_BLT  = 7'd11;
  localparam logic [6:0] OP_BGE  = 7'd12;
  localparam logic [6:0] OP_LUI  = 7'd13;
  localparam logic [6:0] HALT_OP = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [3:0] {
    FETCH, DECODE, EX_R, EX_I, MEM_ADR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q;
  logic                   mem_req;
  logic                   mem_write;
  logic                   adr_sel;
  logic                   taken;

  // State register; reset restarts at FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Retire counter: one tick per entry into FETCH from another state.
  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else if (state_q != FETCH && state_d == FETCH)
      count_q <= count_q + CNT_W'(1);
  end

  // Branch condition for the four branch opcodes.
  always_comb begin
    taken = 1'b0;
    case (Op)
      OP_BEQ:  taken = Zero;
      OP_BNE:  taken = ~Zero;
      OP_BLT:  taken = SignBit;
      OP_BGE:  taken = ~SignBit;
      default: taken = 1'b0;
    endcase
  end

  // Immediate format is decoded from Op regardless of state.
  always_comb begin
    ImmSel = 3'b000;
    case (Op)
      OP_SW:                         ImmSel = 3'b001;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: ImmSel = 3'b010;
      OP_JAL:                        ImmSel = 3'b011;
      OP_LUI:                        ImmSel = 3'b100;
      default:                       ImmSel = 3'b000;
    endcase
  end

  // Next-state and Moore controls.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    adr_sel   = 1'b0;
    IrWrite   = 1'b0;
    PcWrite   = 1'b0;
    PcSrc     = 1'b0;
    RegWrite  = 1'b0;
    AluSrcA   = 2'b00;
    AluSrcB   = 2'b00;
    AluIn     = ALU_ADD;
    ResultSel = 2'b00;
    Done      = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        AluSrcB = 2'b10;
        if (mem.mem_ready) begin
          IrWrite = 1'b1;
          PcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Latch branch/JAL target (OldPC + Imm) into ALUOut.
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        case (Op)
          OP_R:                                  state_d = EX_R;
          OP_ADDI, OP_XORI, OP_ORI, OP_SLTI:     state_d = EX_I;
          OP_LW, OP_SW:                          state_d = MEM_ADR;
          OP_JALR:                               state_d = JALR;
          OP_JAL:                                state_d = JAL;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE:        state_d = BRANCH;
          OP_LUI:                                state_d = LUI;
          HALT_OP:                               state_d = DONE;
          default:                               state_d = FETCH;
        endcase
      end
      EX_R: begin
        AluSrcA = 2'b10;
        AluIn   = F3;
        state_d = WB_ALU;
      end
      EX_I: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        AluIn   = F3;
        state_d = WB_ALU;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEM_ADR: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        state_d = (Op == OP_SW) ? MEM_WR : (Op == OP_LW) ? MEM_RD : FETCH;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (mem.mem_ready) state_d = WB_MEM;
      end
      WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSel = 2'b01;
        state_d   = FETCH;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_sel   = 1'b1;
        if (mem.mem_ready) state_d = FETCH;
      end
      BRANCH: begin
        AluSrcA = 2'b10;
        AluIn   = ALU_SUB;
        PcSrc   = 1'b1;
        PcWrite = taken;
        state_d = FETCH;
      end
      JAL: begin
        RegWrite  = 1'b1;
        ResultSel = 2'b11;
        PcWrite   = 1'b1;
        PcSrc     = 1'b1;
        state_d   = FETCH;
      end
      JALR: begin
        // rd gets the not-yet-updated PC as the return address.
        AluSrcA   = 2'b10;
        AluSrcB   = 2'b01;
        PcWrite   = 1'b1;
        RegWrite  = 1'b1;
        ResultSel = 2'b11;
        state_d   = FETCH;
      end
      LUI: begin
        AluSrcA   = 2'b11;
        AluSrcB   = 2'b01;
        RegWrite  = 1'b1;
        ResultSel = 2'b10;
        state_d   = FETCH;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset cycle: suppress every write/request so an abandoned instruction has no effect.
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      adr_sel   = 1'b0;
      IrWrite   = 1'b0;
      PcWrite   = 1'b0;
      PcSrc     = 1'b0;
      RegWrite  = 1'b0;
      AluSrcA   = 2'b00;
      AluSrcB   = 2'b00;
      AluIn     = ALU_ADD;
      ResultSel = 2'b00;
      Done      = 1'b0;
    end
  end

  assign mem.mem_req  = mem_req;
  assign mem.MemWrite = mem_write;
  assign mem.AdrSel   = adr_sel;
  assign InstrCount   = rst ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams, each instruction expanded into its expected
// per-cycle control words from the instruction-class rules.
module tb_multicycle_controller;

  localparam int unsigned CW = 17;
  localparam logic [6:0] HALT = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic [2:0]  F3;
  logic        Zero, SignBit;
  logic        IrWrite, PcWrite, PcSrc, RegWrite, Done;
  logic [1:0]  AluSrcA, AluSrcB, ResultSel;
  logic [2:0]  AluIn, ImmSel;
  logic [31:0] InstrCount;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .Op(Op), .F3(F3), .Zero(Zero), .SignBit(SignBit),
    .IrWrite(IrWrite), .PcWrite(PcWrite), .PcSrc(PcSrc), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluIn(AluIn), .ResultSel(ResultSel),
    .ImmSel(ImmSel), .Done(Done), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned model_cnt = 0;
  logic [CW-1:0] exp_q[$];
  bit            rdy_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] cw(bit mreq, bit mw, bit adr, bit irw, bit pcw, bit pcs,
                                       bit rw, logic [1:0] asa, logic [1:0] asb,
                                       logic [2:0] alu, logic [1:0] rs, bit done);
    return {mreq, mw, adr, irw, pcw, pcs, rw, asa, asb, alu, rs, done};
  endfunction

  function automatic logic [CW-1:0] obs_cw();
    return {bus.mem_req, bus.MemWrite, bus.AdrSel, IrWrite, PcWrite, PcSrc, RegWrite,
            AluSrcA, AluSrcB, AluIn, ResultSel, Done};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    if (op == 7'd7) return 3'b001;
    if (op >= 7'd9 && op <= 7'd12) return 3'b010;
    if (op == 7'd8) return 3'b011;
    if (op == 7'd13) return 3'b100;
    return 3'b000;
  endfunction

  task automatic push(input logic [CW-1:0] c, input bit r);
    exp_q.push_back(c);
    rdy_q.push_back(r);
  endtask

  // Hold reset n cycles; every control output and the counter must read 0.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_ctl", 32'(obs_cw()), 32'(0));
      chk("rst_cnt", InstrCount, 32'(0));
      chk("rst_imm", 32'(ImmSel), 32'(imm_of(Op)));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    model_cnt = 0;
  endtask

  // One instruction: fw fetch wait cycles, mw data wait cycles; abort_at >= 0
  // applies reset at that cycle of the instruction instead of finishing it.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit z, input bit s,
                           input int fw, input int mw, input int abort_at);
    bit tk;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < fw; i++) push(cw(1,0,0,0,0,0,0,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    push(cw(1,0,0,1,1,0,0,2'd0,2'd2,3'd0,2'd0,0), 1'b1);
    push(cw(0,0,0,0,0,0,0,2'd1,2'd1,3'd0,2'd0,0), 1'($urandom));
    case (op)
      7'd0: begin
        push(cw(0,0,0,0,0,0,0,2'd2,2'd0,f3,2'd0,0), 1'($urandom));
        push(cw(0,0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,0), 1'($urandom));
      end
      7'd2, 7'd3, 7'd4, 7'd5: begin
        push(cw(0,0,0,0,0,0,0,2'd2,2'd1,f3,2'd0,0), 1'($urandom));
        push(cw(0,0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,0), 1'($urandom));
      end
      7'd1: begin
        push(cw(0,0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,0), 1'($urandom));
        for (int i = 0; i < mw; i++) push(cw(1,0,1,0,0,0,0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
        push(cw(1,0,1,0,0,0,0,2'd0,2'd0,3'd0,2'd0,0), 1'b1);
        push(cw(0,0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd1,0), 1'($urandom));
      end
      7'd7: begin
        push(cw(0,0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,0), 1'($urandom));
        for (int i = 0; i < mw; i++) push(cw(1,1,1,0,0,0,0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
        push(cw(1,1,1,0,0,0,0,2'd0,2'd0,3'd0,2'd0,0), 1'b1);
      end
      7'd9, 7'd10, 7'd11, 7'd12: begin
        tk = (op == 7'd9) ? z : (op == 7'd10) ? !z : (op == 7'd11) ? s : !s;
        push(cw(0,0,0,0,tk,1,0,2'd2,2'd0,3'd1,2'd0,0), 1'($urandom));
      end
      7'd8:  push(cw(0,0,0,0,1,1,1,2'd0,2'd0,3'd0,2'd3,0), 1'($urandom));
      7'd6:  push(cw(0,0,0,0,1,0,1,2'd2,2'd1,3'd0,2'd3,0), 1'($urandom));
      7'd13: push(cw(0,0,0,0,0,0,1,2'd3,2'd1,3'd0,2'd2,0), 1'($urandom));
      HALT:  for (int i = 0; i < 10; i++) push(cw(0,0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,1), 1'($urandom));
      default: ;
    endcase
    Op = op; F3 = f3; Zero = z; SignBit = s;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        do_reset(1);
        return;
      end
      bus.mem_ready = rdy_q[i];
      @(negedge clk);
      chk($sformatf("ctl op=%0d step=%0d", op, i), 32'(obs_cw()), 32'(exp_q[i]));
      chk($sformatf("cnt op=%0d step=%0d", op, i), InstrCount, 32'(model_cnt));
      chk($sformatf("imm op=%0d step=%0d", op, i), 32'(ImmSel), 32'(imm_of(op)));
      @(posedge clk); #1;
    end
    if (op != HALT) model_cnt++;
  endtask

  initial begin
    logic [6:0] op;
    rst = 1'b1; bus.mem_ready = 1'b0; Op = '0; F3 = '0; Zero = 1'b0; SignBit = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    // Fetch stalled 3 cycles after reset, then R-type with F3=100.
    run_instr(7'd0, 3'b100, 0, 0, 3, 0, -1);
    run_instr(7'd0, 3'b100, 0, 0, 0, 0, -1);
    run_instr(7'd1, 3'b000, 0, 0, 0, 2, -1);
    run_instr(7'd9,  3'b000, 1, 0, 0, 0, -1);
    run_instr(7'd10, 3'b000, 1, 0, 0, 0, -1);
    run_instr(7'd11, 3'b000, 0, 1, 0, 0, -1);
    run_instr(7'd12, 3'b000, 0, 1, 0, 0, -1);
    run_instr(7'd8,  3'b000, 0, 0, 0, 0, -1);
    run_instr(7'd6,  3'b000, 0, 0, 0, 0, -1);
    run_instr(7'd13, 3'b000, 0, 0, 0, 0, -1);
    run_instr(7'd7,  3'b000, 0, 0, 1, 1, -1);
    run_instr(7'd50, 3'b000, 0, 0, 0, 0, -1);
    for (int n = 0; n < 150; n++) begin
      op = 7'($urandom_range(0, 14));
      if (op == 7'd14) op = 7'($urandom_range(14, 126));
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    // Reset during a stalled store, then confirm a clean restart.
    run_instr(7'd7, 3'b000, 0, 0, 0, 3, 4);
    run_instr(7'd0, 3'b010, 0, 0, 0, 0, -1);
    run_instr(HALT, 3'b000, 0, 0, 0, 0, -1);
    do_reset(1);
    run_instr(7'd2, 3'b110, 0, 0, 1, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
